piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 144 ++++++++++++++
 tb/tb_piso_serializer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for the parallel-in serial-out transmitter.
// The master side supplies words; the slave side (the serializer) emits framed bits.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             eof;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sof, eof
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sof, eof
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per enabled clock with sof/eof framing.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             shift_en,
  piso_serializer_if.slave bus
);

  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = CW'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             sout_r;
  logic             sout_valid_r;
  logic             sof_r;
  logic             eof_r;
  logic             ready_s;
  logic             accept_s;

  // Bit that leaves the word first for the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Word with its first-to-leave bit removed, so the next bit becomes first.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Ready depends only on state, count and reset so there is no loop through din_valid.
  always_comb begin
    ready_s = 1'b0;
    if (!rs) begin
      ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      ready_s = 1'b1;
    end else if (cnt_r == LAST) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // A word is taken only on an enabled edge with both sides agreeing.
  always_comb begin
    accept_s = bus.din_valid & ready_s & shift_en;
  end

  assign bus.din_ready  = ready_s;
  assign bus.sout       = sout_r;
  assign bus.sout_valid = sout_valid_r;
  assign bus.sof        = sof_r;
  assign bus.eof        = eof_r;

  // Framing FSM; a new word is loaded straight from din so its first bit shows with zero gap.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO;
      shreg_r      <= '0;
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
    end else if (shift_en) begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= SHIFT;
            cnt_r        <= ZERO;
            shreg_r      <= drop_bit(bus.din);
            sout_r       <= first_bit(bus.din);
            sout_valid_r <= 1'b1;
            sof_r        <= 1'b1;
            eof_r        <= 1'b0;
          end else begin
            state_r      <= IDLE;
            cnt_r        <= ZERO;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sof_r        <= 1'b0;
            eof_r        <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_r != LAST) begin
            cnt_r        <= cnt_r + ONE;
            shreg_r      <= drop_bit(shreg_r);
            sout_r       <= first_bit(shreg_r);
            sout_valid_r <= 1'b1;
            sof_r        <= 1'b0;
            eof_r        <= (cnt_r == PRE_LAST);
          end else if (accept_s) begin
            state_r      <= SHIFT;
            cnt_r        <= ZERO;
            shreg_r      <= drop_bit(bus.din);
            sout_r       <= first_bit(bus.din);
            sout_valid_r <= 1'b1;
            sof_r        <= 1'b1;
            eof_r        <= 1'b0;
          end else begin
            state_r      <= IDLE;
            cnt_r        <= ZERO;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sof_r        <= 1'b0;
            eof_r        <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= ZERO;
          sout_r       <= 1'b0;
          sout_valid_r <= 1'b0;
          sof_r        <= 1'b0;
          eof_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: three configurations (4-bit MSB-first,
// 4-bit LSB-first, 8-bit MSB-first) checked against a word-level bit-order model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rs = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] din_all = 8'h00;
  logic [2:0] valid_v = 3'b000;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;
  logic [4:0] obs;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();
  piso_serializer_if #(.WIDTH(8)) if2 ();

  assign if0.din       = din_all[3:0];
  assign if0.din_valid = valid_v[0];
  assign if1.din       = din_all[3:0];
  assign if1.din_valid = valid_v[1];
  assign if2.din       = din_all;
  assign if2.din_valid = valid_v[2];

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rs(rs), .shift_en(shift_en), .bus(if0.slave));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rs(rs), .shift_en(shift_en), .bus(if1.slave));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rs(rs), .shift_en(shift_en), .bus(if2.slave));

  // Observed tuple {sout, sout_valid, sof, eof, din_ready} of the selected instance.
  always_comb begin
    obs = 5'b00000;
    case (sel)
      0: obs = {if0.sout, if0.sout_valid, if0.sof, if0.eof, if0.din_ready};
      1: obs = {if1.sout, if1.sout_valid, if1.sof, if1.eof, if1.din_ready};
      2: obs = {if2.sout, if2.sout_valid, if2.sof, if2.eof, if2.din_ready};
      default: obs = 5'b00000;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 2) ? 8 : 4;
  endfunction

  // Reference: i-th transmitted bit of a word for the given width and order.
  function automatic logic exp_bit(input logic [7:0] w, input int width, input bit msb, input int i);
    return msb ? w[width - 1 - i] : w[i];
  endfunction

  function automatic logic [4:0] exp_frame(input logic [7:0] w, input int width, input bit msb, input int i);
    return {exp_bit(w, width, msb, i), 1'b1, (i == 0), (i == width - 1), (i == width - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    shift_en = 1'b1;
    valid_v  = 3'b111;
    din_all  = 8'($urandom);
    rs       = 1'b0;
    repeat (3) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        sel = s;
        #0.1;
        if (obs !== 5'b00000) begin
          bad++;
          $display("FAIL reset_hold s=%0d got=%b want=%b", s, obs, 5'b00000);
        end
        total++;
      end
    end
    valid_v = 3'b000;
    rs = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0.1;
      if (obs !== 5'b00001) begin
        bad++;
        $display("FAIL reset_release s=%0d got=%b want=%b", s, obs, 5'b00001);
      end
      total++;
    end
    tick();
  endtask

  task automatic test_word(input int s, input logic [7:0] directed, input int n_rand);
    int         w_len;
    bit         msb;
    logic [7:0] w;
    sel   = s;
    w_len = width_of(s);
    msb   = (s != 1);
    for (int k = 0; k <= n_rand; k++) begin
      w = (k == 0) ? directed : 8'($urandom);
      if (w_len == 4) w[7:4] = 4'h0;
      din_all = w;
      valid_v = 3'b000;
      valid_v[s] = 1'b1;
      #1;
      if (obs !== 5'b00001) begin
        bad++;
        $display("FAIL word_idle s=%0d got=%b want=%b", s, obs, 5'b00001);
      end
      total++;
      tick();
      valid_v = 3'b000;
      din_all = 8'($urandom);
      for (int i = 0; i < w_len; i++) begin
        if (obs !== exp_frame(w, w_len, msb, i)) begin
          bad++;
          $display("FAIL word s=%0d w=%h bit%0d got=%b want=%b", s, w, i, obs, exp_frame(w, w_len, msb, i));
        end
        total++;
        tick();
      end
      if (obs !== 5'b00001) begin
        bad++;
        $display("FAIL word_end s=%0d w=%h got=%b want=%b", s, w, obs, 5'b00001);
      end
      total++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    sel = 0;
    q = {8'h0B, 8'h06};
    repeat (4) q.push_back({4'h0, 4'($urandom)});
    din_all = q[0];
    valid_v = 3'b001;
    tick();
    for (int j = 0; j < q.size(); j++) begin
      if (j == q.size() - 1) begin
        valid_v = 3'b000;
        din_all = 8'($urandom);
      end else begin
        din_all = q[j + 1];
      end
      for (int i = 0; i < 4; i++) begin
        if (obs !== exp_frame(q[j], 4, 1'b1, i)) begin
          bad++;
          $display("FAIL b2b word%0d bit%0d got=%b want=%b", j, i, obs, exp_frame(q[j], 4, 1'b1, i));
        end
        total++;
        tick();
      end
    end
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL b2b_end got=%b want=%b", obs, 5'b00001);
    end
    total++;
  endtask

  task automatic test_stall();
    logic [7:0] w;
    int         idx;
    bit         se;
    sel = 0;
    // No accept while disabled even with valid and ready both high.
    shift_en = 1'b0;
    din_all  = 8'h0C;
    valid_v  = 3'b001;
    repeat (2) tick();
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL stall_idle got=%b want=%b", obs, 5'b00001);
    end
    total++;
    shift_en = 1'b1;
    tick();
    valid_v = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (obs !== exp_frame(8'h0C, 4, 1'b1, i)) begin
        bad++;
        $display("FAIL stall_dir bit%0d got=%b want=%b", i, obs, exp_frame(8'h0C, 4, 1'b1, i));
      end
      total++;
      if (i == 1) begin
        shift_en = 1'b0;
        repeat (3) begin
          tick();
          if (obs !== exp_frame(8'h0C, 4, 1'b1, 1)) begin
            bad++;
            $display("FAIL stall_hold got=%b want=%b", obs, exp_frame(8'h0C, 4, 1'b1, 1));
          end
          total++;
        end
        shift_en = 1'b1;
      end
      tick();
    end
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL stall_end got=%b want=%b", obs, 5'b00001);
    end
    total++;
    // Random enable pattern: the bit index only advances on enabled edges.
    for (int k = 0; k < 6; k++) begin
      w = {4'h0, 4'($urandom)};
      din_all  = w;
      valid_v  = 3'b001;
      shift_en = 1'b1;
      tick();
      valid_v = 3'b000;
      idx = 0;
      while (idx < 4) begin
        if (obs !== exp_frame(w, 4, 1'b1, idx)) begin
          bad++;
          $display("FAIL stall_rand w=%h bit%0d got=%b want=%b", w, idx, obs, exp_frame(w, 4, 1'b1, idx));
        end
        total++;
        se = ($urandom_range(0, 2) != 0);
        shift_en = se;
        tick();
        if (se) idx++;
      end
      shift_en = 1'b1;
      if (obs !== 5'b00001) begin
        bad++;
        $display("FAIL stall_rand_end w=%h got=%b want=%b", w, obs, 5'b00001);
      end
      total++;
    end
  endtask

  task automatic test_reset_mid_word();
    sel = 0;
    din_all = 8'h0A;
    valid_v = 3'b001;
    tick();
    valid_v = 3'b000;
    tick();
    if (obs !== exp_frame(8'h0A, 4, 1'b1, 1)) begin
      bad++;
      $display("FAIL mid_pre got=%b want=%b", obs, exp_frame(8'h0A, 4, 1'b1, 1));
    end
    total++;
    #2;
    rs = 1'b0;
    #1;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL mid_async got=%b want=%b", obs, 5'b00000);
    end
    total++;
    din_all = 8'h05;
    valid_v = 3'b001;
    tick();
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL mid_inreset got=%b want=%b", obs, 5'b00000);
    end
    total++;
    valid_v = 3'b000;
    rs = 1'b1;
    #1;
    din_all = 8'h01;
    valid_v = 3'b001;
    tick();
    valid_v = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (obs !== exp_frame(8'h01, 4, 1'b1, i)) begin
        bad++;
        $display("FAIL mid_after bit%0d got=%b want=%b", i, obs, exp_frame(8'h01, 4, 1'b1, i));
      end
      total++;
      tick();
    end
    if (obs !== 5'b00001) begin
      bad++;
      $display("FAIL mid_end got=%b want=%b", obs, 5'b00001);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_word(0, 8'h0B, 4);
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_word(1, 8'h0B, 4);
    test_word(2, 8'hA5, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
